// File: rtl/audio_codec_slave.sv
// Audio codec slave: deserialises left-justified DAC slots into parallel words
// and serialises parallel ADC words onto AUD_ADCDAT, all synchronous to clk.
module audio_codec_slave #(
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 AUD_BCLK,
   input  logic                 AUD_DACLRCK,
   input  logic                 AUD_DACDAT,
   input  logic                 AUD_ADCLRCK,
   output logic                 AUD_ADCDAT,
   output logic [DATA_BITS-1:0] dac_sample,
   output logic                 dac_channel,
   output logic                 dac_valid,
   output logic                 short_frame,
   input  logic [DATA_BITS-1:0] adc_left,
   input  logic [DATA_BITS-1:0] adc_right,
   output logic [1:0]           adc_load
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DONE
   } rx_state_t;

   rx_state_t state;
   rx_state_t state_next;

   logic bclk_q;
   logic dlrck_q;
   logic alrck_q;
   logic bclk_rise;
   logic bclk_fall;
   logic dlrck_edge;
   logic alrck_edge;

   logic [CNT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_slot;
   logic                 word_ready;
   logic                 take_bit;
   logic                 last_bit;
   logic                 short_hit;

   logic [DATA_BITS-1:0] tx_shift;

   // Loaded every cycle, reset included, so no edge is seen right after release.
   always_ff @(posedge clk) begin
      bclk_q  <= AUD_BCLK;
      dlrck_q <= AUD_DACLRCK;
      alrck_q <= AUD_ADCLRCK;
   end

   assign bclk_rise  = AUD_BCLK & ~bclk_q;
   assign bclk_fall  = ~AUD_BCLK & bclk_q;
   assign dlrck_edge = AUD_DACLRCK != dlrck_q;
   assign alrck_edge = AUD_ADCLRCK != alrck_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (dlrck_edge) begin
         state_next = CAPTURE;
      end else if (state == CAPTURE && bclk_rise && bit_cnt == LAST_BIT) begin
         state_next = DONE;
      end
   end

   // A frame edge always wins over a same-cycle bit clock rise.
   always_comb begin
      take_bit  = 1'b0;
      last_bit  = 1'b0;
      short_hit = 1'b0;
      if (state == CAPTURE) begin
         take_bit  = bclk_rise && !dlrck_edge;
         last_bit  = take_bit && (bit_cnt == LAST_BIT);
         short_hit = dlrck_edge && (bit_cnt != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bit_cnt    <= '0;
         rx_shift   <= '0;
         rx_slot    <= 1'b0;
         word_ready <= 1'b0;
      end else begin
         word_ready <= last_bit;
         if (dlrck_edge) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_slot  <= AUD_DACLRCK;
         end else if (take_bit) begin
            rx_shift <= {rx_shift[DATA_BITS-2:0], AUD_DACDAT};
            bit_cnt  <= bit_cnt + CNT_W'(1);
         end
      end
   end

   // The completed word is presented one cycle after RX enters DONE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dac_sample  <= '0;
         dac_channel <= 1'b0;
         dac_valid   <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         dac_valid   <= word_ready;
         short_frame <= short_hit;
         if (word_ready) begin
            dac_sample  <= rx_shift;
            dac_channel <= rx_slot;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_shift <= '0;
         adc_load <= 2'b00;
      end else begin
         adc_load <= 2'b00;
         if (alrck_edge) begin
            tx_shift <= AUD_ADCLRCK ? adc_left : adc_right;
            adc_load <= {AUD_ADCLRCK, ~AUD_ADCLRCK};
         end else if (bclk_fall) begin
            tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
         end
      end
   end

   assign AUD_ADCDAT = tx_shift[DATA_BITS-1];

endmodule
